// File: rtl/voice_mixer.sv
// Eight-voice mono mixer: gated serial accumulate, Q1.7 gain, saturate.
// Ports: clk, rst (sync, active-high); voice_1_in..voice_8_in, note_on,
//   data_valid_in, master_gain in; mix_out/mix_valid with mix_ready
//   handshake out; busy, clip (sticky), overrun (sticky).
// Optional: define MIXER_AUTO_NORM_EN to divide the sum by roughly the
//   active voice count (shift by ceil(log2(n))) before the gain.
module voice_mixer #(
  parameter int AUDIO_WIDTH = 32,
  parameter int NUM_VOICES  = 8,
  parameter int GAIN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [AUDIO_WIDTH-1:0] voice_1_in,
  input  logic signed [AUDIO_WIDTH-1:0] voice_2_in,
  input  logic signed [AUDIO_WIDTH-1:0] voice_3_in,
  input  logic signed [AUDIO_WIDTH-1:0] voice_4_in,
  input  logic signed [AUDIO_WIDTH-1:0] voice_5_in,
  input  logic signed [AUDIO_WIDTH-1:0] voice_6_in,
  input  logic signed [AUDIO_WIDTH-1:0] voice_7_in,
  input  logic signed [AUDIO_WIDTH-1:0] voice_8_in,
  input  logic [NUM_VOICES-1:0]         note_on,
  input  logic                          data_valid_in,
  input  logic [GAIN_WIDTH-1:0]         master_gain,
  output logic [AUDIO_WIDTH-1:0]        mix_out,
  output logic                          mix_valid,
  input  logic                          mix_ready,
  output logic                          busy,
  output logic                          clip,
  output logic                          overrun
);

  localparam int AW     = AUDIO_WIDTH;
  localparam int ACC_W  = AW + 3;
  localparam int PROD_W = ACC_W + GAIN_WIDTH + 1;
  localparam int IDX_W  = $clog2(NUM_VOICES);

  localparam logic signed [PROD_W-1:0] SMAX =
    {{(PROD_W-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SMIN =
    {{(PROD_W-AW+1){1'b1}}, {(AW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ACCUM, SCALE, SAT, OUT
  } state_t;

  state_t state, state_nx;

  logic signed [AW-1:0]     voice_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]    note_on_q;
  logic [GAIN_WIDTH-1:0]    gain_q;
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic signed [PROD_W-1:0] scaled_q;

  logic signed [AW-1:0]     voice_sel;
  logic signed [ACC_W-1:0]  voice_ext;
  logic signed [ACC_W-1:0]  acc_n;
  logic signed [PROD_W-1:0] acc_x;
  logic signed [PROD_W-1:0] gain_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled_c;
  logic [AW-1:0]            sat_val;
  logic                     sat_hit;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (data_valid_in) state_nx = ACCUM;
      ACCUM: if (idx == IDX_W'(NUM_VOICES-1)) state_nx = SCALE;
      SCALE: state_nx = SAT;
      SAT:   state_nx = OUT;
      OUT:   if (mix_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = (state != IDLE);
  end

  assign voice_sel = voice_q[idx];
  assign voice_ext = {{(ACC_W-AW){voice_sel[AW-1]}}, voice_sel};

`ifdef MIXER_AUTO_NORM_EN
  logic [3:0] n_on;
  logic [1:0] sh;

  // shift = ceil(log2(active voices))
  always_comb begin
    n_on = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      n_on = n_on + 4'(note_on_q[i]);
    if (n_on <= 4'd1)      sh = 2'd0;
    else if (n_on == 4'd2) sh = 2'd1;
    else if (n_on <= 4'd4) sh = 2'd2;
    else                   sh = 2'd3;
    acc_n = acc >>> sh;
  end
`else
  assign acc_n = acc;
`endif

  // gain is unsigned, so it gets a zero sign bit
  always_comb begin
    acc_x    = {{(PROD_W-ACC_W){acc_n[ACC_W-1]}}, acc_n};
    gain_x   = {{(PROD_W-GAIN_WIDTH){1'b0}}, gain_q};
    prod     = acc_x * gain_x;
    scaled_c = prod >>> 7;
  end

  always_comb begin
    sat_hit = 1'b0;
    sat_val = scaled_q[AW-1:0];
    if (scaled_q > SMAX) begin
      sat_hit = 1'b1;
      sat_val = {1'b0, {(AW-1){1'b1}}};
    end else if (scaled_q < SMIN) begin
      sat_hit = 1'b1;
      sat_val = {1'b1, {(AW-1){1'b0}}};
    end
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++)
        voice_q[i] <= '0;
      note_on_q <= '0;
      gain_q    <= '0;
      acc       <= '0;
      idx       <= '0;
      scaled_q  <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_valid_in) begin
            voice_q[0] <= voice_1_in;
            voice_q[1] <= voice_2_in;
            voice_q[2] <= voice_3_in;
            voice_q[3] <= voice_4_in;
            voice_q[4] <= voice_5_in;
            voice_q[5] <= voice_6_in;
            voice_q[6] <= voice_7_in;
            voice_q[7] <= voice_8_in;
            note_on_q  <= note_on;
            gain_q     <= master_gain;
            acc        <= '0;
            idx        <= '0;
          end
        end
        ACCUM: begin
          if (note_on_q[idx]) acc <= acc + voice_ext;
          idx <= idx + 1'b1;
        end
        SCALE: scaled_q <= scaled_c;
        SAT: begin
          mix_out   <= sat_val;
          mix_valid <= 1'b1;
          if (sat_hit) clip <= 1'b1;
        end
        OUT: if (mix_ready) mix_valid <= 1'b0;
        default: ;
      endcase
      if (data_valid_in && state != IDLE)
        overrun <= 1'b1;
    end
  end

endmodule
